// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI memory responder.
// Opcodes follow the common serial flash READ/WRITE set.
package spi_resp_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_mem_responder_if.sv
// Byte-wide memory request/acknowledge bus.
// master issues requests, slave acknowledges with read data.
interface spi_mem_responder_if #(
  parameter int AW = 16
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses
// taken from the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target bridging READ/WRITE frames onto a byte
// memory port; all SPI pins are oversampled on wb_clk.
module spi_mem_responder
  import spi_resp_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  spi_mem_responder_if.master mem
);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic mosi_meta_q, mosi_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk  (wb_clk),
    .rst  (wb_rst),
    .d    (spi_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk  (wb_clk),
    .rst  (wb_rst),
    .d    (spi_ss),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  state_e        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    abyte_q, abyte_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    buf_q, buf_d;
  logic          buf_vld_q, buf_vld_d;
  logic          first_q, first_d;
  logic          is_rd_q, is_rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          miso_q, miso_d;
  logic          oe_q, oe_d;
  logic [7:0]    rx_byte, cur;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    abyte_d   = abyte_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    first_d   = first_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    req_d     = req_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    miso_d    = miso_q;
    rx_byte   = {rx_q[6:0], mosi_q};
    cur       = tx_q;

    // First read byte goes straight to tx; later ones wait in buf
    if (req_q && mem.mem_ack) begin
      req_d  = 1'b0;
      addr_d = addr_q + 1'b1;
      if (!we_q) begin
        if (first_q) begin
          tx_d = mem.mem_rdata;
        end else begin
          buf_d     = mem.mem_rdata;
          buf_vld_d = 1'b1;
        end
      end
    end

    if (ss_rise) begin
      state_d   = IDLE;
      first_d   = 1'b0;
      buf_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d = CMD;
            bit_d   = 3'd0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            rx_d  = rx_byte;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              abyte_d = 2'd0;
              is_rd_d = (rx_byte == OP_READ);
              if (rx_byte == OP_READ || rx_byte == OP_WRITE)
                state_d = ADDR;
              else
                state_d = IGNORE;
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_d = {addr_q[AW-2:0], mosi_q};
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              abyte_d = abyte_q + 2'd1;
              if (abyte_q == 2'd2) begin
                state_d   = is_rd_q ? READ : WRITE;
                first_d   = is_rd_q;
                buf_vld_d = 1'b0;
                if (is_rd_q && !req_d) begin
                  req_d = 1'b1;
                  we_d  = 1'b0;
                end
              end
            end
          end
        end
        READ: begin
          if (sck_rise) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd0 && !req_d) begin
              req_d = 1'b1;
              we_d  = 1'b0;
            end
          end else if (sck_fall) begin
            if (bit_q == 3'd0) begin
              // A missing prefetch leaves tx as-is: byte repeats
              cur = tx_d;
              if (!first_q && buf_vld_d) begin
                cur       = buf_d;
                buf_vld_d = 1'b0;
              end
              first_d = 1'b0;
              tx_d    = cur;
              miso_d  = cur[7];
            end else begin
              miso_d = tx_q[~bit_q];
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            rx_d  = rx_byte;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7 && !req_d) begin
              req_d   = 1'b1;
              we_d    = 1'b1;
              wdata_d = rx_byte;
            end
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end

    oe_d = (state_d == READ);
    if (!oe_d) miso_d = 1'b0;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      state_q     <= IDLE;
      bit_q       <= 3'd0;
      abyte_q     <= 2'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      buf_q       <= 8'h00;
      buf_vld_q   <= 1'b0;
      first_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= 8'h00;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_q      <= mosi_meta_q;
      state_q     <= state_d;
      bit_q       <= bit_d;
      abyte_q     <= abyte_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      first_q     <= first_d;
      is_rd_q     <= is_rd_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
    end
  end

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = oe_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: random SPI frames checked
// against a frame-level model of memory and request traffic.
module tb_spi_mem_responder;
  import spi_resp_pkg::*;

  localparam int H = 6;

  logic clk = 1'b0;
  logic wb_rst = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_ss = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe;

  spi_mem_responder_if #(.AW(16)) mem_if ();

  spi_mem_responder #(.AW(16)) dut (
    .wb_clk      (clk),
    .wb_rst      (wb_rst),
    .spi_sck     (spi_sck),
    .spi_ss      (spi_ss),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem         (mem_if)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int seed;
  logic [7:0] mem_arr [int];
  logic [7:0] ref_mem [int];
  logic [24:0] act_q [$];
  logic [24:0] exp_q [$];
  int act_base = 0;

  function automatic logic [7:0] init_val(input int a);
    logic [31:0] h;
    if (a == 32'h100) return 8'hA5;
    if (a == 32'h101) return 8'h5A;
    if (a == 32'h102) return 8'hC3;
    h = a * 32'h9E3779B1 + seed;
    return h[20:13];
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    int m = a & 32'hFFFF;
    return ref_mem.exists(m) ? ref_mem[m] : init_val(m);
  endfunction

  // Memory slave: one-cycle acknowledge, logs every request
  always @(posedge clk) begin
    if (mem_if.mem_ack) begin
      mem_if.mem_ack <= 1'b0;
    end else if (mem_if.mem_req) begin
      mem_if.mem_ack <= 1'b1;
      act_q.push_back({mem_if.mem_we, mem_if.mem_addr,
                       mem_if.mem_we ? mem_if.mem_wdata : 8'h00});
      if (mem_if.mem_we)
        mem_arr[int'(mem_if.mem_addr)] = mem_if.mem_wdata;
      else if (mem_arr.exists(int'(mem_if.mem_addr)))
        mem_if.mem_rdata <= mem_arr[int'(mem_if.mem_addr)];
      else
        mem_if.mem_rdata <= init_val(int'(mem_if.mem_addr));
    end
  end

  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic [7:0] oe);
    rx = 8'h00;
    oe = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = tx[7-k];
      repeat (H) @(posedge clk);
      #1;
      rx[7-k] = spi_miso;
      oe[7-k] = spi_miso_oe;
      spi_sck = 1'b1;
      repeat (H) @(posedge clk);
      #1;
      spi_sck = 1'b0;
    end
  endtask

  task automatic quiet_byte(input string tag, input logic [7:0] b);
    logic [7:0] r, o;
    spi_bits(b, 8, r, o);
    check({tag, "_miso"}, r, 0);
    check({tag, "_oe"}, o, 0);
  endtask

  task automatic ss_begin();
    spi_ss = 1'b0;
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic ss_end();
    repeat (H) @(posedge clk);
    #1;
    spi_ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ss_idle", 32'(dut.state_q), 32'(IDLE));
    check("ss_oe", spi_miso_oe, 0);
    repeat (4 * H) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] op, input int a);
    logic [7:0] hi = 8'($urandom);
    quiet_byte("hdr", op);
    quiet_byte("hdr", hi);
    quiet_byte("hdr", 8'(a >> 8));
    quiet_byte("hdr", 8'(a));
  endtask

  task automatic check_reqs();
    check("req_count", act_q.size() - act_base, exp_q.size());
    for (int k = 0; k < exp_q.size() && act_base + k < act_q.size(); k++)
      check("req", 32'(act_q[act_base + k]), 32'(exp_q[k]));
    act_base = act_q.size();
    exp_q.delete();
  endtask

  task automatic read_frame(input int a, input int n);
    logic [7:0] r, o;
    ss_begin();
    send_hdr(OP_READ, a);
    for (int i = 0; i <= n; i++)
      exp_q.push_back({1'b0, 16'((a + i) & 32'hFFFF), 8'h00});
    for (int i = 0; i < n; i++) begin
      spi_bits(8'($urandom), 8, r, o);
      check("rd_data", r, ref_rd(a + i));
      check("rd_oe", o, 8'hFF);
    end
    ss_end();
    check_reqs();
  endtask

  task automatic write_frame(input int a, input int n, input int part);
    logic [7:0] d, r, o;
    ss_begin();
    send_hdr(OP_WRITE, a);
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      quiet_byte("wr", d);
      ref_mem[(a + i) & 32'hFFFF] = d;
      exp_q.push_back({1'b1, 16'((a + i) & 32'hFFFF), d});
    end
    if (part > 0) begin
      spi_bits(8'($urandom), part, r, o);
      check("wr_part_oe", o, 0);
    end
    ss_end();
    check_reqs();
  endtask

  task automatic junk_frame(input logic [7:0] op, input int n);
    ss_begin();
    quiet_byte("junk", op);
    for (int i = 0; i < n; i++) quiet_byte("junk", 8'($urandom));
    ss_end();
    check_reqs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, spi_miso, 0);
    check({tag, "_oe"}, spi_miso_oe, 0);
    check({tag, "_req"}, mem_if.mem_req, 0);
    check({tag, "_we"}, mem_if.mem_we, 0);
    check({tag, "_addr"}, mem_if.mem_addr, 0);
    check({tag, "_wdata"}, mem_if.mem_wdata, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, n, kind;
    logic [7:0] op, r, o;
    seed = int'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    wb_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    read_frame(32'h0100, 3);
    write_frame(32'h1234, 2, 0);
    read_frame(32'h1234, 2);
    junk_frame(8'h9F, 4);
    read_frame(32'h0100, 1);
    read_frame(32'hFFFF, 2);
    write_frame(int'($urandom_range(0, 65535)), 0, 5);

    for (int f = 0; f < 8; f++) begin
      kind = int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 65535));
      n = int'($urandom_range(1, 4));
      if (f == 3) a = 32'hFFFE;
      if (kind == 0) begin
        read_frame(a, n);
      end else if (kind == 1) begin
        write_frame(a, n, int'($urandom_range(0, 7)));
        read_frame(a, n);
      end else begin
        op = 8'($urandom);
        if (op == OP_READ || op == OP_WRITE) op = 8'hA0;
        junk_frame(op, n);
      end
    end

    // Asynchronous reset in the middle of a READ data phase
    ss_begin();
    send_hdr(OP_READ, 32'h4321);
    spi_bits(8'h00, 8, r, o);
    check("mid_data", r, ref_rd(32'h4321));
    check("mid_oe_pre", spi_miso_oe, 1);
    #2;
    wb_rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    spi_ss = 1'b1;
    spi_sck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wb_rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    act_base = act_q.size();
    exp_q.delete();

    read_frame(32'h0100, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

SPI mode-0 target that answers the SoC's SPI flash/RAM initiator and bridges its READ (0x03) and WRITE (0x02) commands onto a byte-wide memory request/acknowledge port. It is the far end of the initiator's SPI link: the boot/data memory model on the FPGA test harness, or the on-die memory front-end. All SPI pins are oversampled on the system clock; there is no SCK clock domain.

## Interface
- AW, default 16: memory address width; the low AW bits of the 24-bit SPI address are used; AW ≤ 24.
- wb_clk  in  1  system clock; must be ≥ 8× SCK frequency.
- wb_rst  in  1  reset; asynchronous, active-high.
- spi_sck  in  1  SPI clock from the initiator; idles low (mode 0).
- spi_ss  in  1  active-low select.
- spi_mosi  in  1  initiator-to-target data, MSB first.
- spi_miso  out  1  target-to-initiator data.
- spi_miso_oe  out  1  high while selected in READ data phase.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  AW  byte address; valid while mem_req.
- mem_wdata  out  8  write data; valid while mem_req & mem_we.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  8  read data.

## Operation
- spi_sck, spi_ss, spi_mosi pass through 2-FF synchronizers; rise/fall of SCK and SS detected on synchronized values.
- Bit sampling on synchronized SCK rise (MOSI shifted into rx register, MSB first); MISO updated on SCK fall.
- States: IDLE → CMD (on SS fall) → ADDR (after 8 bits) → READ or WRITE (after 24 address bits); any other opcode → IGNORE until SS rises.
- Any state → IDLE on synchronized SS rise; SS rise beats a simultaneous SCK edge.
- READ: mem read of addr issued on the cycle the 24th address bit is sampled; data loaded into tx register on ack; MSB driven on the next SCK fall. Next-byte prefetch issued when the first bit of the current byte is sampled; loaded into tx on the fall after the 8th bit. Streaming continues until SS rises.
- WRITE: after each 8th data bit, mem write of the received byte at addr is issued.
- Address increments by 1 after each ack, modulo 2^AW.
- If a new request is needed while mem_req is still pending: WRITE drops the new byte; READ repeats the previous tx byte. Both indicate ack-latency violation.
- SS rise with a partial byte: partial byte discarded; a pending mem_req stays asserted until ack, then no further requests.
- spi_miso_oe high only in READ data phase with SS low; spi_miso = 0 whenever oe is low.
- Reset values: spi_miso 0, spi_miso_oe 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0; state IDLE; synchronizers reset to SS=1, SCK=0, MOSI=0.

## Timing
- Input latency: 2 wb_clk synchronizer + 1 edge detect; SCK high and low phases each ≥ 4 wb_clk.
- mem_ack must arrive ≤ 2 wb_clk after mem_req rises for the first READ byte. Later bytes tolerate ≥ 6 SCK half-periods.
- mem_req rises 1 wb_clk after the triggering detected edge; deasserts the cycle after mem_ack.
- Full-duplex: MISO is 0 during CMD/ADDR; the MOSI byte received during READ is ignored.

## Structure
- Package spi_resp_pkg: opcode constants OP_READ = 8'h03, OP_WRITE = 8'h02; state enum {IDLE, CMD, ADDR, READ, WRITE, IGNORE}.
- Sub-module spi_sync_edge: 2-FF synchronizer with rise/fall pulse outputs, instantiated for SCK and SS. MOSI uses sync only.
- Remaining logic in one module: FSM, 3-bit bit counter, 2-bit address-byte counter, rx/tx shift registers, address counter, request handshake.

## Test plan
- READ 0x03, address 0x000100, 3 bytes clocked, memory returns 0xA5,0x5A,0xC3 with 1-cycle ack → MISO bytes A5,5A,C3; mem_addr 0x0100,0x0101,0x0102; oe high only in data phase.
- WRITE 0x02, address 0x001234, data 0x11,0x22 → two writes: (0x1234,0x11), (0x1235,0x22); no third request.
- Opcode 0x9F followed by 4 bytes → no mem_req, MISO 0, oe 0; next 0x03 frame after SS toggle works normally.
- READ starting at 0xFFFF (AW=16), 2 bytes → addresses 0xFFFF then 0x0000.
- SS rises after 5 bits of a WRITE data byte → no write issued; FSM IDLE within 3 wb_clk; wb_rst pulsed mid-READ → all outputs at reset values immediately (asynchronous).
